cuppa_wvb_acq_ctrl: RTL and testbench

Acquisition sequencer for one CUPPA waveform buffer (wvb) channel. It consumes the unpacked wvb configuration fields (arm, trig_mode, cnst_run, cnst_conf, test_conf, post_conf, pre_conf). It selects and qualifies the trigger source and generates the buffer write-enable window for each event, covering pre-trigger plus post-trigger samples. It sits between the configuration fan-out, the discriminator, the software trigger strobe and the wvb sample writer.

---
 rtl/cuppa_wvb_acq_ctrl_pkg.sv | 17 +
 rtl/cuppa_wvb_cnst_timer.sv | 28 ++
 rtl/cuppa_wvb_acq_ctrl.sv | 141 ++++++++++++++
 tb/tb_cuppa_wvb_acq_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cuppa_wvb_acq_ctrl_pkg.sv
// Shared state encodings and trigger-source codes for the wvb acquisition sequencer.
package cuppa_wvb_acq_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREFILL  = 3'd1,
        S_ARMED    = 3'd2,
        S_TEST_DLY = 3'd3,
        S_CAPTURE  = 3'd4
    } acq_state_t;

    localparam logic [1:0] TRIG_SRC_NONE = 2'b00;
    localparam logic [1:0] TRIG_SRC_THR  = 2'b01;
    localparam logic [1:0] TRIG_SRC_TEST = 2'b10;
    localparam logic [1:0] TRIG_SRC_CNST = 2'b11;

endpackage

// File: rtl/cuppa_wvb_cnst_timer.sv
// Free-running period timer for forced (constant) triggers; fire is a one-cycle
// pulse when the count reaches the period, after which counting restarts at 0.
module cuppa_wvb_cnst_timer
    import cuppa_wvb_acq_ctrl_pkg::*;
#(
    parameter int P_W = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           enable,
    input  logic [P_W-1:0] period,
    output logic           fire
);

    logic [P_W-1:0] count;

    // >= rather than == so a period lowered below the running count still fires
    assign fire = enable && !clear && (period != '0) && (count >= period);

    always_ff @(posedge clk) begin
        if (rst || clear || fire)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/cuppa_wvb_acq_ctrl.sv
// Acquisition sequencer for one wvb channel: trigger selection/qualification and
// generation of the pre+post trigger write-enable window.
module cuppa_wvb_acq_ctrl
    import cuppa_wvb_acq_ctrl_pkg::*;
#(
    parameter int P_PRE_W  = 6,
    parameter int P_POST_W = 15,
    parameter int P_LEN_W  = 16,
    parameter int P_MISS_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arm,
    input  logic                trig_mode,
    input  logic                cnst_run,
    input  logic [P_POST_W-1:0] cnst_conf,
    input  logic [P_POST_W-1:0] test_conf,
    input  logic [P_POST_W-1:0] post_conf,
    input  logic [P_PRE_W-1:0]  pre_conf,
    input  logic                thr_trig,
    input  logic                sw_trig,
    input  logic                buf_afull,
    output logic                wr_en,
    output logic                evt_start,
    output logic                evt_end,
    output logic [1:0]          trig_src,
    output logic                armed,
    output logic [P_MISS_W-1:0] miss_cnt
);

    acq_state_t          state;
    logic [P_POST_W-1:0] cnt;
    logic [P_LEN_W-1:0]  len;
    logic [P_LEN_W-1:0]  evt_len;

    logic       last_cap, can_trig, busy;
    logic       thr_hit, sw_hit, cn_hit, tdly_fire, cnst_fire;
    logic       accept, drop, miss_inc;
    logic [1:0] fire_src;

    assign evt_len = P_LEN_W'(pre_conf) + P_LEN_W'(post_conf) + P_LEN_W'(1);

    // The final capture sample doubles as an armed cycle so back-to-back events abut.
    assign last_cap  = (state == S_CAPTURE) && (len == P_LEN_W'(1));
    assign can_trig  = arm && ((state == S_ARMED) || last_cap);
    assign thr_hit   = can_trig && !trig_mode && thr_trig;
    assign sw_hit    = can_trig && trig_mode && sw_trig;
    assign cn_hit    = can_trig && cnst_fire;
    assign tdly_fire = (state == S_TEST_DLY) && arm && (cnt == '0);
    assign busy      = (state == S_PREFILL) || (state == S_TEST_DLY) ||
                       ((state == S_CAPTURE) && !last_cap);

    cuppa_wvb_cnst_timer #(.P_W(P_POST_W)) u_cnst_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!can_trig),
        .enable (cnst_run),
        .period (cnst_conf),
        .fire   (cnst_fire)
    );

    always_comb begin
        fire_src = TRIG_SRC_NONE;
        if (thr_hit)
            fire_src = TRIG_SRC_THR;
        else if (tdly_fire)
            fire_src = TRIG_SRC_TEST;
        else if (cn_hit && !sw_hit)
            fire_src = TRIG_SRC_CNST;
    end

    assign accept   = (fire_src != TRIG_SRC_NONE) && !buf_afull;
    assign drop     = (fire_src != TRIG_SRC_NONE) && buf_afull;
    assign miss_inc = drop || (busy && (thr_trig || sw_trig));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            len       <= '0;
            wr_en     <= 1'b0;
            evt_start <= 1'b0;
            evt_end   <= 1'b0;
            trig_src  <= TRIG_SRC_NONE;
            armed     <= 1'b0;
            miss_cnt  <= '0;
        end else begin
            wr_en     <= 1'b0;
            evt_start <= 1'b0;
            evt_end   <= 1'b0;
            armed     <= 1'b0;
            if (miss_inc && (miss_cnt != '1))
                miss_cnt <= miss_cnt + 1'b1;

            if (accept) begin
                state     <= S_CAPTURE;
                len       <= evt_len;
                trig_src  <= fire_src;
                wr_en     <= 1'b1;
                evt_start <= 1'b1;
                evt_end   <= (evt_len == P_LEN_W'(1));
            end else begin
                case (state)
                    S_IDLE: begin
                        if (arm) begin
                            state <= S_PREFILL;
                            cnt   <= P_POST_W'(pre_conf);
                        end
                    end
                    S_PREFILL, S_TEST_DLY: begin
                        // A test fire that reached here was dropped on buf_afull.
                        if (!arm)
                            state <= S_IDLE;
                        else if (cnt == '0) begin
                            state <= S_ARMED;
                            armed <= 1'b1;
                        end else
                            cnt <= cnt - 1'b1;
                    end
                    S_ARMED, S_CAPTURE: begin
                        if ((state == S_CAPTURE) && !last_cap) begin
                            len     <= len - 1'b1;
                            wr_en   <= 1'b1;
                            evt_end <= (len == P_LEN_W'(2));
                        end else if (!arm)
                            state <= S_IDLE;
                        else if (sw_hit) begin
                            state <= S_TEST_DLY;
                            cnt   <= test_conf;
                        end else begin
                            state <= S_ARMED;
                            armed <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cuppa_wvb_acq_ctrl.sv
// Scoreboard bench: stimulus pushes expected events, a negedge monitor checks framing.
module tb_cuppa_wvb_acq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0;
    logic        trig_mode = 1'b0;
    logic        cnst_run = 1'b0;
    logic [14:0] cnst_conf = '0;
    logic [14:0] test_conf = '0;
    logic [14:0] post_conf = '0;
    logic [5:0]  pre_conf = '0;
    logic        thr_trig = 1'b0;
    logic        sw_trig = 1'b0;
    logic        buf_afull = 1'b0;
    logic        wr_en, evt_start, evt_end, armed;
    logic [1:0]  trig_src;
    logic [15:0] miss_cnt;

    cuppa_wvb_acq_ctrl dut (
        .clk(clk), .rst(rst), .arm(arm), .trig_mode(trig_mode), .cnst_run(cnst_run),
        .cnst_conf(cnst_conf), .test_conf(test_conf), .post_conf(post_conf),
        .pre_conf(pre_conf), .thr_trig(thr_trig), .sw_trig(sw_trig),
        .buf_afull(buf_afull), .wr_en(wr_en), .evt_start(evt_start),
        .evt_end(evt_end), .trig_src(trig_src), .armed(armed), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         start;
        int         len;
        logic [1:0] src;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int start, input int len, input logic [1:0] src);
        exp_t e;
        e.start = start;
        e.len   = len;
        e.src   = src;
        sb.push_back(e);
    endtask

    task automatic reset_dut();
        rst = 1'b1; arm = 1'b0; trig_mode = 1'b0; cnst_run = 1'b0; cnst_conf = '0;
        test_conf = '0; post_conf = '0; pre_conf = '0; thr_trig = 1'b0;
        sw_trig = 1'b0; buf_afull = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_outputs", {wr_en, evt_start, evt_end, trig_src, armed, miss_cnt}, 32'd0);
    endtask

    task automatic wait_armed(input int lim);
        for (int i = 0; i < lim && !armed; i++) tick();
        chk("armed_wait", armed, 1);
    endtask

    task automatic pulse_thr();
        thr_trig = 1'b1; tick(); thr_trig = 1'b0;
    endtask

    // Monitor: frames each event from evt_start to evt_end and compares with the queue head.
    bit   in_evt = 0;
    int   m_start, m_len;
    logic [1:0] m_src;

    always @(negedge clk) begin
        if (!rst) begin
            if (evt_start) begin
                if (in_evt) begin
                    n_fail++;
                    $display("FAIL evt_overlap: got evt_start inside event at cycle %0d", cyc);
                end
                in_evt  = 1;
                m_start = cyc;
                m_len   = 0;
                m_src   = trig_src;
            end
            if (wr_en) begin
                if (!in_evt) begin
                    n_fail++;
                    $display("FAIL stray_wr_en: got wr_en=1 expected 0 at cycle %0d", cyc);
                end
                m_len++;
            end
            if (in_evt && trig_src !== m_src) begin
                n_fail++;
                $display("FAIL src_hold: got %0h expected %0h", trig_src, m_src);
            end
            if (evt_end) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_underflow: got event at %0d expected none", m_start);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("evt_start_cycle", m_start, e.start);
                    chk("evt_len", m_len, e.len);
                    chk("evt_src", m_src, e.src);
                end
                in_evt = 0;
            end
        end
    end

    initial begin
        int r;
        // Basic threshold event: pre=4, post=10 -> 15 samples
        reset_dut();
        pre_conf = 6'd4; post_conf = 15'd10;
        arm = 1'b1; r = cyc;
        repeat (5) tick();
        chk("armed_early", armed, 0);
        tick();
        chk("armed_at_n+6", armed, 1);
        push(cyc + 1, 15, 2'b01);
        pulse_thr();
        repeat (20) tick();
        chk("thr_src_hold", trig_src, 2'b01);
        chk("thr_rearmed", armed, 1);
        chk("thr_miss", miss_cnt, 0);

        // Constant run: 1-sample events every 100 cycles
        reset_dut();
        cnst_run = 1'b1; cnst_conf = 15'd99;
        arm = 1'b1; r = cyc;
        push(r + 102, 1, 2'b11);
        push(r + 202, 1, 2'b11);
        push(r + 302, 1, 2'b11);
        while (cyc < r + 350) tick();
        arm = 1'b0; cnst_run = 1'b0;
        tick(); tick();

        // Test delay with a threshold pulse ignored during the delay
        reset_dut();
        trig_mode = 1'b1; test_conf = 15'd7; pre_conf = 6'd2; post_conf = 15'd3;
        arm = 1'b1;
        wait_armed(20);
        push(cyc + 9, 6, 2'b10);
        sw_trig = 1'b1; tick(); sw_trig = 1'b0;
        tick(); tick();
        pulse_thr();
        repeat (15) tick();
        chk("tdly_miss", miss_cnt, 1);

        // Buffer almost full: three drops, then a normal event
        reset_dut();
        pre_conf = 6'd1; post_conf = 15'd2;
        arm = 1'b1;
        wait_armed(20);
        buf_afull = 1'b1;
        repeat (3) begin pulse_thr(); tick(); end
        chk("afull_miss", miss_cnt, 3);
        chk("afull_armed", armed, 1);
        buf_afull = 1'b0;
        push(cyc + 1, 4, 2'b01);
        pulse_thr();
        repeat (10) tick();

        // Disarm mid-capture, then re-arm repeats prefill
        reset_dut();
        pre_conf = 6'd3; post_conf = 15'd16;
        arm = 1'b1;
        wait_armed(20);
        push(cyc + 1, 20, 2'b01);
        pulse_thr();
        repeat (5) tick();
        arm = 1'b0;
        repeat (25) tick();
        chk("disarm_idle", armed, 0);
        arm = 1'b1;
        repeat (4) tick();
        chk("rearm_prefill", armed, 0);
        tick();
        chk("rearm_armed", armed, 1);

        // Threshold and constant fire together, then miss saturation
        reset_dut();
        cnst_run = 1'b1; cnst_conf = 15'd9;
        arm = 1'b1; r = cyc;
        while (cyc < r + 11) tick();
        push(cyc + 1, 1, 2'b01);
        pulse_thr();
        while (cyc < r + 15) tick();
        cnst_run = 1'b0;
        tick();
        chk("simul_miss", miss_cnt, 0);
        buf_afull = 1'b1; thr_trig = 1'b1;
        repeat (70000) tick();
        thr_trig = 1'b0; buf_afull = 1'b0;
        tick();
        chk("miss_saturate", miss_cnt, 16'hFFFF);

        tick(); tick();
        chk("sb_empty", sb.size(), 0);
        chk("evt_closed", in_evt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
